eco32f_hazard_ctrl: RTL and testbench

- Parametrised interlock controller between decode and execute.
- Generalises the single-cycle load-use bubble to a configurable load latency.
- Adds front-end stalls for multi-cycle MUL/DIV/REM and an external stall input.
- Supports pipeline flush. Decode consumes `id_bubble` and `id_stall` directly.

---
 rtl/eco32f_hazard_ctrl.sv | 82 ++++++++
 tb/tb_eco32f_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_hazard_ctrl.sv
// Decode/execute interlock: load-use bubbles over a configurable load latency,
// front-end freeze while the multi-cycle MUL/DIV unit is occupied or downstream stalls.
module eco32f_hazard_ctrl #(
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rf_x_addr,
    input  logic [4:0]       id_rf_y_addr,
    input  logic             id_uses_x,
    input  logic             id_uses_y,
    input  logic [4:0]       id_rf_r_addr,
    input  logic             id_rf_r_we,
    input  logic             id_op_load,
    input  logic             id_op_mul,
    input  logic             id_op_div,
    input  logic             flush,
    input  logic             ext_stall,
    output logic             id_bubble,
    output logic             id_stall,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] mdu_count
);

    localparam int unsigned AW = 5;

    logic [LOAD_LAT-1:0] r_ld_v;
    logic [AW-1:0]       r_ld_addr [LOAD_LAT];
    logic [CNT_W-1:0]    r_mdu_cnt;

    logic w_frz;
    logic w_hit_x;
    logic w_hit_y;
    logic w_issue;
    logic w_ld_new;

    assign mdu_busy  = (r_mdu_cnt != '0);
    assign mdu_count = r_mdu_cnt;
    assign w_frz     = ext_stall | mdu_busy;
    assign id_stall  = w_frz;

    // Match decode sources against every pending load destination; r0 never hazards.
    always_comb begin
        w_hit_x = 1'b0;
        w_hit_y = 1'b0;
        for (int i = 0; i < int'(LOAD_LAT); i++) begin
            if (r_ld_v[i] && (r_ld_addr[i] == id_rf_x_addr)) w_hit_x = 1'b1;
            if (r_ld_v[i] && (r_ld_addr[i] == id_rf_y_addr)) w_hit_y = 1'b1;
        end
        w_hit_x = w_hit_x & (id_rf_x_addr != '0);
        w_hit_y = w_hit_y & (id_rf_y_addr != '0);
    end

    assign id_bubble = id_valid & ~w_frz & ((id_uses_x & w_hit_x) | (id_uses_y & w_hit_y));
    assign w_issue   = id_valid & ~w_frz & ~id_bubble & ~flush;
    assign w_ld_new  = w_issue & id_op_load & id_rf_r_we & (id_rf_r_addr != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ld_v    <= '0;
            r_mdu_cnt <= '0;
            for (int i = 0; i < int'(LOAD_LAT); i++) r_ld_addr[i] <= '0;
        end else if (w_frz) begin
            // The unit keeps running when it is the only source of the freeze.
            if ((r_mdu_cnt != '0) && !ext_stall) r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
        end else begin
            for (int i = int'(LOAD_LAT) - 1; i > 0; i--) begin
                r_ld_v[i]    <= r_ld_v[i-1];
                r_ld_addr[i] <= r_ld_addr[i-1];
            end
            r_ld_v[0]    <= w_ld_new;
            r_ld_addr[0] <= id_rf_r_addr;
            if (w_issue && id_op_div)      r_mdu_cnt <= CNT_W'(DIV_CYCLES - 1);
            else if (w_issue && id_op_mul) r_mdu_cnt <= CNT_W'(MUL_CYCLES - 1);
        end
    end

endmodule

// File: tb/tb_eco32f_hazard_ctrl.sv
// Scoreboard bench: two instances (LOAD_LAT=3/MUL=4/DIV=32 and the 1/1/1 legacy
// configuration) share stimulus and are checked against a per-register age model.
module tb_eco32f_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_uses_x, id_uses_y, id_rf_r_we;
    logic       id_op_load, id_op_mul, id_op_div, flush, ext_stall;
    logic [4:0] id_rf_x_addr, id_rf_y_addr, id_rf_r_addr;

    logic       bub0, stl0, busy0;
    logic [5:0] cnt0;
    logic       bub1, stl1, busy1;
    logic [0:0] cnt1;

    eco32f_hazard_ctrl #(.LOAD_LAT(3), .MUL_CYCLES(4), .DIV_CYCLES(32)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rf_x_addr(id_rf_x_addr), .id_rf_y_addr(id_rf_y_addr),
        .id_uses_x(id_uses_x), .id_uses_y(id_uses_y),
        .id_rf_r_addr(id_rf_r_addr), .id_rf_r_we(id_rf_r_we),
        .id_op_load(id_op_load), .id_op_mul(id_op_mul), .id_op_div(id_op_div),
        .flush(flush), .ext_stall(ext_stall),
        .id_bubble(bub0), .id_stall(stl0), .mdu_busy(busy0), .mdu_count(cnt0)
    );

    eco32f_hazard_ctrl #(.LOAD_LAT(1), .MUL_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rf_x_addr(id_rf_x_addr), .id_rf_y_addr(id_rf_y_addr),
        .id_uses_x(id_uses_x), .id_uses_y(id_uses_y),
        .id_rf_r_addr(id_rf_r_addr), .id_rf_r_we(id_rf_r_we),
        .id_op_load(id_op_load), .id_op_mul(id_op_mul), .id_op_div(id_op_div),
        .flush(flush), .ext_stall(ext_stall),
        .id_bubble(bub1), .id_stall(stl1), .mdu_busy(busy1), .mdu_count(cnt1)
    );

    typedef struct {
        logic bub;
        logic stl;
        logic busy;
        int   cnt;
    } exp_t;

    exp_t sb_q0[$];
    exp_t sb_q1[$];

    int p_lat [2] = '{3, 1};
    int p_mul [2] = '{4, 1};
    int p_div [2] = '{32, 1};

    // Model: remaining visibility cycles per register, plus the occupancy count.
    int m_ld  [2][32];
    int m_cnt [2];

    int n_checks = 0;
    int n_errors = 0;
    int stall_acc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input int k, input logic [4:0] a);
        return (a != 5'd0) && (m_ld[k][a] != 0);
    endfunction

    task automatic m_flags(input int k, output logic frz, output logic bub, output logic iss);
        frz = ext_stall || (m_cnt[k] != 0);
        bub = id_valid && !frz && ((id_uses_x && m_hit(k, id_rf_x_addr)) ||
                                   (id_uses_y && m_hit(k, id_rf_y_addr)));
        iss = id_valid && !frz && !bub && !flush;
    endtask

    task automatic push_expect();
        for (int k = 0; k < 2; k++) begin
            logic frz, bub, iss;
            exp_t e;
            m_flags(k, frz, bub, iss);
            e.bub  = bub;
            e.stl  = frz;
            e.busy = (m_cnt[k] != 0);
            e.cnt  = m_cnt[k];
            if (k == 0) sb_q0.push_back(e);
            else        sb_q1.push_back(e);
        end
    endtask

    task automatic compare_outputs();
        exp_t e;
        e = sb_q0.pop_front();
        chk("u0.bubble", 32'(bub0), 32'(e.bub));
        chk("u0.stall",  32'(stl0), 32'(e.stl));
        chk("u0.busy",   32'(busy0), 32'(e.busy));
        chk("u0.count",  32'(cnt0), 32'(e.cnt));
        e = sb_q1.pop_front();
        chk("u1.bubble", 32'(bub1), 32'(e.bub));
        chk("u1.stall",  32'(stl1), 32'(e.stl));
        chk("u1.busy",   32'(busy1), 32'(e.busy));
        chk("u1.count",  32'(cnt1), 32'(e.cnt));
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            for (int r = 0; r < 32; r++) m_ld[k][r] = 0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic frz, bub, iss;
            m_flags(k, frz, bub, iss);
            if (rst || flush) begin
                m_cnt[k] = 0;
                for (int r = 0; r < 32; r++) m_ld[k][r] = 0;
            end else if (frz) begin
                if (m_cnt[k] != 0 && !ext_stall) m_cnt[k]--;
            end else begin
                for (int r = 0; r < 32; r++) if (m_ld[k][r] != 0) m_ld[k][r]--;
                if (iss && id_op_load && id_rf_r_we && id_rf_r_addr != 5'd0)
                    m_ld[k][id_rf_r_addr] = p_lat[k];
                if (iss && id_op_div)      m_cnt[k] = p_div[k] - 1;
                else if (iss && id_op_mul) m_cnt[k] = p_mul[k] - 1;
            end
        end
    endtask

    // One clock: expectations queued, outputs compared on the falling edge.
    task automatic step();
        push_expect();
        @(negedge clk);
        compare_outputs();
        if (stl0) stall_acc++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_op(input logic [4:0] x, input logic ux, input logic [4:0] y, input logic uy,
                          input logic [4:0] r, input logic we,
                          input logic ld, input logic mul, input logic div);
        id_valid = 1'b1;
        id_rf_x_addr = x; id_uses_x = ux;
        id_rf_y_addr = y; id_uses_y = uy;
        id_rf_r_addr = r; id_rf_r_we = we;
        id_op_load = ld; id_op_mul = mul; id_op_div = div;
    endtask

    task automatic nop();
        set_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        step();
        rst = 1'b0;
        steps(1);

        // Load-use: LDW r5 then ADD r6,r5,r1.
        set_op(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); step();
        set_op(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); steps(4);
        nop(); steps(2);

        // Load r7, reader on y.
        set_op(5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0); step();
        set_op(5'd3, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); steps(4);

        // Load r0 never hazards.
        set_op(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        set_op(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); steps(2);
        nop(); steps(3);

        // Divide then a held follower: 31 stall cycles on the 32-cycle unit.
        set_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); step();
        stall_acc = 0;
        set_op(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); steps(34);
        chk("div.stall_cycles", 32'(stall_acc), 32'd31);

        // Multiply: 3 stall cycles.
        set_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0); step();
        stall_acc = 0;
        set_op(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); steps(6);
        chk("mul.stall_cycles", 32'(stall_acc), 32'd3);

        // Divide with 5 external stall cycles in the middle: 36 stall cycles.
        set_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); step();
        stall_acc = 0;
        nop(); steps(10);
        ext_stall = 1'b1; steps(5);
        ext_stall = 1'b0; steps(25);
        chk("divext.stall_cycles", 32'(stall_acc), 32'd36);

        // Pending load holds under ext_stall; reader bubbles only afterwards.
        set_op(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0); step();
        set_op(5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        ext_stall = 1'b1; steps(3);
        ext_stall = 1'b0; steps(5);
        nop(); steps(2);

        // Flush at count 10 with r9 pending.
        set_op(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0); step();
        set_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); step();
        nop(); steps(21);
        chk("flush.pre_count", 32'(cnt0), 32'd10);
        flush = 1'b1; step();
        flush = 1'b0;
        set_op(5'd9, 1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); steps(2);

        // Issue together with flush records nothing.
        set_op(5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        flush = 1'b1; step();
        flush = 1'b0;
        set_op(5'd10, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); steps(2);

        // Reset mid-divide (count 20) with a load pending.
        set_op(5'd1, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0); step();
        set_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); step();
        nop(); steps(11);
        chk("rst.pre_count", 32'(cnt0), 32'd20);
        rst = 1'b1; step();
        rst = 1'b0;
        set_op(5'd11, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); steps(2);
        ext_stall = 1'b1; step();
        ext_stall = 1'b0;

        // Random mix over a small register set.
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            set_op(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'(sel < 40), 1'(sel >= 40 && sel < 46), 1'(sel >= 46 && sel < 48));
            id_valid  = 1'($urandom_range(0, 9) != 0);
            flush     = 1'($urandom_range(0, 24) == 0);
            ext_stall = 1'($urandom_range(0, 9) == 0);
            step();
        end
        flush = 1'b0; ext_stall = 1'b0; nop(); steps(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
